// File: rtl/ex_stage_core_pkg.sv
// ex_pkg: shared definitions for the MIPS32 execute stage.
//   - R-type funct field constants
//   - ALUCtrl instruction-class constants from the main decoder
//   - aluOpE: the decoded ALU operation (exported on ALUOp for debug)
package ex_pkg;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_MFHI = 6'h10;
    localparam logic [5:0] FN_MFLO = 6'h12;
    localparam logic [5:0] FN_MUL  = 6'h18;
    localparam logic [5:0] FN_DIV  = 6'h1A;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SLT  = 6'h2A;

    localparam logic [2:0] CLS_R   = 3'b000;
    localparam logic [2:0] CLS_ADD = 3'b001;
    localparam logic [2:0] CLS_SUB = 3'b010;
    localparam logic [2:0] CLS_OR  = 3'b011;
    localparam logic [2:0] CLS_LUI = 3'b100;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_SLL  = 4'd2,
        OP_OR   = 4'd3,
        OP_SLT  = 4'd4,
        OP_LUI  = 4'd5,
        OP_MUL  = 4'd6,
        OP_DIV  = 4'd7,
        OP_MFHI = 4'd8,
        OP_MFLO = 4'd9
    } aluOpE;

endpackage

// File: rtl/ex_stage_core_if.sv
// ex_stage_core_if: bundles the execute-stage ALU and forwarding signals.
//   master: the surrounding pipeline (drives operands/control, reads results)
//   slave : ex_stage_core (reads operands/control, drives ALUOp/ALUOut/ForA/ForB/ForC)
interface ex_stage_core_if;

    logic [5:0]  Funct;
    logic [2:0]  ALUCtrl;
    logic [31:0] A;
    logic [31:0] B;
    logic [4:0]  Shamt;
    logic [3:0]  ALUOp;
    logic [31:0] ALUOut;

    logic [4:0]  IDEX_RegRs;
    logic [4:0]  IDEX_RegRt;
    logic [4:0]  EXMEM_RegRd;
    logic [4:0]  MEMWB_RegRd;
    logic        EXMEM_RegWrite;
    logic        EXMEM_MemWrite;
    logic        MEMWB_RegWrite;
    logic        MEMWB_MemToReg;
    logic [1:0]  ForA;
    logic [1:0]  ForB;
    logic        ForC;

    modport master (
        output Funct, ALUCtrl, A, B, Shamt,
        output IDEX_RegRs, IDEX_RegRt, EXMEM_RegRd, MEMWB_RegRd,
        output EXMEM_RegWrite, EXMEM_MemWrite, MEMWB_RegWrite, MEMWB_MemToReg,
        input  ALUOp, ALUOut, ForA, ForB, ForC
    );

    modport slave (
        input  Funct, ALUCtrl, A, B, Shamt,
        input  IDEX_RegRs, IDEX_RegRt, EXMEM_RegRd, MEMWB_RegRd,
        input  EXMEM_RegWrite, EXMEM_MemWrite, MEMWB_RegWrite, MEMWB_MemToReg,
        output ALUOp, ALUOut, ForA, ForB, ForC
    );

endinterface

// File: rtl/ex_fwd_unit.sv
// ex_fwd_unit: combinational forwarding-select logic.
//   IDEX_RegRs/IDEX_RegRt : sources of the instruction in EX
//   EXMEM_* / MEMWB_*     : destination and control of the instructions in MEM/WB
//   ForA/ForB             : 00 regfile, 01 MEM/WB result, 10 EX/MEM result
//   ForC                  : 1 selects MEM/WB load data as store data in MEM
module ex_fwd_unit (
    input  logic [4:0] IDEX_RegRs,
    input  logic [4:0] IDEX_RegRt,
    input  logic [4:0] EXMEM_RegRd,
    input  logic [4:0] MEMWB_RegRd,
    input  logic       EXMEM_RegWrite,
    input  logic       EXMEM_MemWrite,
    input  logic       MEMWB_RegWrite,
    input  logic       MEMWB_MemToReg,
    output logic [1:0] ForA,
    output logic [1:0] ForB,
    output logic       ForC
);

    // A store in MEM carries its rt in EXMEM_RegRd, so it must never look
    // like a producer to the EX-stage operand muxes.
    logic exValid;
    logic wbValid;

    assign exValid = EXMEM_RegWrite && !EXMEM_MemWrite && (EXMEM_RegRd != '0);
    assign wbValid = MEMWB_RegWrite && (MEMWB_RegRd != '0);

    always_comb begin
        ForA = 2'b00;
        ForB = 2'b00;
        if (exValid && (EXMEM_RegRd == IDEX_RegRs)) begin
            ForA = 2'b10;
        end else if (wbValid && (MEMWB_RegRd == IDEX_RegRs)) begin
            ForA = 2'b01;
        end
        if (exValid && (EXMEM_RegRd == IDEX_RegRt)) begin
            ForB = 2'b10;
        end else if (wbValid && (MEMWB_RegRd == IDEX_RegRt)) begin
            ForB = 2'b01;
        end
    end

    // Load in WB feeding the store data of a store in MEM.
    assign ForC = EXMEM_MemWrite && MEMWB_MemToReg && wbValid
                  && (MEMWB_RegRd == EXMEM_RegRd);

endmodule

// File: rtl/ex_stage_core.sv
// ex_stage_core: MIPS32 execute-stage datapath core.
//   Clock, Reset : single clock, asynchronous active-high reset (clears HI/LO)
//   bus (slave)  : Funct/ALUCtrl/A/B/Shamt in, ALUOp/ALUOut out,
//                  forwarding inputs in, ForA/ForB/ForC out
// ALU decode, datapath and forwarding are combinational; HI/LO load on a
// DIV with non-zero divisor at the rising clock edge.
module ex_stage_core
    import ex_pkg::*;
(
    input logic           Clock,
    input logic           Reset,
    ex_stage_core_if.slave bus
);

    aluOpE       aluOp;
    logic [31:0] hiReg;
    logic [31:0] loReg;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        divByZero;

    always_comb begin
        aluOp = OP_ADD;
        case (bus.ALUCtrl)
            CLS_R: begin
                case (bus.Funct)
                    FN_SUB:  aluOp = OP_SUB;
                    FN_SLL:  aluOp = OP_SLL;
                    FN_SLT:  aluOp = OP_SLT;
                    FN_MUL:  aluOp = OP_MUL;
                    FN_DIV:  aluOp = OP_DIV;
                    FN_MFHI: aluOp = OP_MFHI;
                    FN_MFLO: aluOp = OP_MFLO;
                    default: aluOp = OP_ADD;   // add, jr and unknown functs
                endcase
            end
            CLS_SUB: aluOp = OP_SUB;
            CLS_OR:  aluOp = OP_OR;
            CLS_LUI: aluOp = OP_LUI;
            default: aluOp = OP_ADD;
        endcase
    end

    assign bus.ALUOp = aluOp;

    // Signed / and % truncate toward zero with the remainder following the
    // dividend's sign, matching MIPS div.
    assign divByZero = (bus.B == '0);
    assign quotient  = divByZero ? '0 : 32'($signed(bus.A) / $signed(bus.B));
    assign remainder = divByZero ? '0 : 32'($signed(bus.A) % $signed(bus.B));

    always_comb begin
        bus.ALUOut = '0;
        case (aluOp)
            OP_ADD:  bus.ALUOut = bus.A + bus.B;
            OP_SUB:  bus.ALUOut = bus.A - bus.B;
            OP_SLL:  bus.ALUOut = bus.B << bus.Shamt;
            OP_OR:   bus.ALUOut = bus.A | bus.B;
            OP_SLT:  bus.ALUOut = {31'b0, ($signed(bus.A) < $signed(bus.B))};
            OP_LUI:  bus.ALUOut = {bus.B[15:0], 16'h0000};
            // The low word of a product is identical for signed and unsigned operands.
            OP_MUL:  bus.ALUOut = bus.A * bus.B;
            OP_DIV:  bus.ALUOut = '0;
            OP_MFHI: bus.ALUOut = hiReg;
            OP_MFLO: bus.ALUOut = loReg;
            default: bus.ALUOut = '0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            hiReg <= '0;
            loReg <= '0;
        end else if ((aluOp == OP_DIV) && !divByZero) begin
            hiReg <= remainder;
            loReg <= quotient;
        end
    end

    ex_fwd_unit fwdUnit (
        .IDEX_RegRs     (bus.IDEX_RegRs),
        .IDEX_RegRt     (bus.IDEX_RegRt),
        .EXMEM_RegRd    (bus.EXMEM_RegRd),
        .MEMWB_RegRd    (bus.MEMWB_RegRd),
        .EXMEM_RegWrite (bus.EXMEM_RegWrite),
        .EXMEM_MemWrite (bus.EXMEM_MemWrite),
        .MEMWB_RegWrite (bus.MEMWB_RegWrite),
        .MEMWB_MemToReg (bus.MEMWB_MemToReg),
        .ForA           (bus.ForA),
        .ForB           (bus.ForB),
        .ForC           (bus.ForC)
    );

endmodule

// File: tb/tb_ex_stage_core.sv
// Testbench for ex_stage_core: directed vectors with literal expectations,
// plus a behavioural model compared against the DUT on every falling edge.
module tb_ex_stage_core;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ex_stage_core_if bus ();

    ex_stage_core dut (
        .Clock (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] hiM = '0;
    logic [31:0] loM = '0;

    function automatic logic isDiv(input logic [2:0] c, input logic [5:0] f);
        return (c == 3'b000) && (f == 6'h1A);
    endfunction

    function automatic logic [31:0] expOut(input logic [2:0] c, input logic [5:0] f,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [4:0] sh,
                                           input logic [31:0] hi, input logic [31:0] lo);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (c == 3'b010) return a - b;
        if (c == 3'b011) return a | b;
        if (c == 3'b100) return b * 32'h0001_0000;
        if (c != 3'b000) return a + b;
        case (f)
            6'h22:   return a - b;
            6'h00:   return b << sh;
            6'h2A:   return (sa < sb) ? 32'd1 : 32'd0;
            6'h18:   return sa * sb;
            6'h1A:   return 32'd0;
            6'h10:   return hi;
            6'h12:   return lo;
            default: return a + b;
        endcase
    endfunction

    function automatic logic [3:0] expOp(input logic [2:0] c, input logic [5:0] f);
        if (c == 3'b010) return 4'd1;
        if (c == 3'b011) return 4'd3;
        if (c == 3'b100) return 4'd5;
        if (c != 3'b000) return 4'd0;
        case (f)
            6'h22:   return 4'd1;
            6'h00:   return 4'd2;
            6'h2A:   return 4'd4;
            6'h18:   return 4'd6;
            6'h1A:   return 4'd7;
            6'h10:   return 4'd8;
            6'h12:   return 4'd9;
            default: return 4'd0;
        endcase
    endfunction

    function automatic logic [1:0] expFor(input logic [4:0] r);
        if (bus.EXMEM_RegWrite && !bus.EXMEM_MemWrite && bus.EXMEM_RegRd != 0 && bus.EXMEM_RegRd == r)
            return 2'b10;
        if (bus.MEMWB_RegWrite && bus.MEMWB_RegRd != 0 && bus.MEMWB_RegRd == r)
            return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic expForC();
        return bus.EXMEM_MemWrite && bus.MEMWB_RegWrite && bus.MEMWB_MemToReg
               && bus.MEMWB_RegRd != 0 && bus.MEMWB_RegRd == bus.EXMEM_RegRd;
    endfunction

    // Signed division from magnitudes: quotient toward zero, remainder = a - q*b.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hiM <= '0;
            loM <= '0;
        end else if (isDiv(bus.ALUCtrl, bus.Funct) && bus.B != 0) begin
            longint sa, sb, qm, q;
            sa = longint'($signed(bus.A));
            sb = longint'($signed(bus.B));
            qm = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
            q  = ((sa < 0) != (sb < 0)) ? -qm : qm;
            loM <= 32'(q);
            hiM <= 32'(sa - q * sb);
        end
    end

    always @(negedge clk) begin
        check("model.ALUOut", bus.ALUOut,
              expOut(bus.ALUCtrl, bus.Funct, bus.A, bus.B, bus.Shamt, hiM, loM));
        check("model.ALUOp", 32'(bus.ALUOp), 32'(expOp(bus.ALUCtrl, bus.Funct)));
        check("model.ForA", 32'(bus.ForA), 32'(expFor(bus.IDEX_RegRs)));
        check("model.ForB", 32'(bus.ForB), 32'(expFor(bus.IDEX_RegRt)));
        check("model.ForC", 32'(bus.ForC), 32'(expForC()));
    end

    // ---------------- directed stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic setAlu(input logic [2:0] c, input logic [5:0] f,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        bus.ALUCtrl = c;
        bus.Funct   = f;
        bus.A       = a;
        bus.B       = b;
        bus.Shamt   = sh;
    endtask

    task automatic alu(input string name, input logic [2:0] c, input logic [5:0] f,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                       input logic [31:0] exp);
        setAlu(c, f, a, b, sh);
        #1;
        check(name, bus.ALUOut, exp);
        tick();
    endtask

    task automatic setFwd(input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] exRd, input logic [4:0] wbRd,
                          input logic exRw, input logic exMw,
                          input logic wbRw, input logic wbM2r);
        bus.IDEX_RegRs     = rs;
        bus.IDEX_RegRt     = rt;
        bus.EXMEM_RegRd    = exRd;
        bus.MEMWB_RegRd    = wbRd;
        bus.EXMEM_RegWrite = exRw;
        bus.EXMEM_MemWrite = exMw;
        bus.MEMWB_RegWrite = wbRw;
        bus.MEMWB_MemToReg = wbM2r;
    endtask

    task automatic fwd(input string name, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] exRd, input logic [4:0] wbRd,
                       input logic exRw, input logic exMw, input logic wbRw, input logic wbM2r,
                       input logic [1:0] eA, input logic [1:0] eB, input logic eC);
        setFwd(rs, rt, exRd, wbRd, exRw, exMw, wbRw, wbM2r);
        #1;
        check({name, ".ForA"}, 32'(bus.ForA), 32'(eA));
        check({name, ".ForB"}, 32'(bus.ForB), 32'(eB));
        check({name, ".ForC"}, 32'(bus.ForC), 32'(eC));
        tick();
    endtask

    initial begin
        setFwd(0, 0, 0, 0, 0, 0, 0, 0);
        setAlu(3'b000, 6'h10, 32'd0, 32'd0, 5'd0);
        tick();
        tick();
        check("resetMfhi", bus.ALUOut, 32'd0);
        check("resetForA", 32'(bus.ForA), 32'd0);
        rst = 1'b0;
        tick();

        alu("add",   3'b000, 6'h20, 32'd5, 32'd7, 5'd0, 32'd12);
        alu("sub",   3'b000, 6'h22, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE);
        alu("slt",   3'b000, 6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd1);
        alu("sltNo", 3'b000, 6'h2A, 32'd1, 32'hFFFF_FFFF, 5'd0, 32'd0);
        alu("lui",   3'b100, 6'h00, 32'd0, 32'h1234_ABCD, 5'd0, 32'hABCD_0000);
        alu("sll31", 3'b000, 6'h00, 32'd0, 32'd1, 5'd31, 32'h8000_0000);
        alu("ori",   3'b011, 6'h3F, 32'h0F00_00F0, 32'h0000_FF0F, 5'd0, 32'h0F00_FFFF);
        alu("beqSub",3'b010, 6'h20, 32'd3, 32'd10, 5'd0, 32'hFFFF_FFF9);
        alu("cls7",  3'b111, 6'h22, 32'd4, 32'd9, 5'd0, 32'd13);
        alu("jr",    3'b000, 6'h08, 32'h100, 32'h4, 5'd0, 32'h104);
        alu("unkFn", 3'b000, 6'h3F, 32'd1, 32'd2, 5'd0, 32'd3);
        alu("mulM1", 3'b000, 6'h18, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'hFFFF_FFFF);
        alu("mul0",  3'b000, 6'h18, 32'hFFFF_FFFF, 32'd0, 5'd0, 32'd0);
        alu("mulNeg",3'b000, 6'h18, 32'hFFFF_FFFD, 32'd7, 5'd0, 32'hFFFF_FFEB);

        setAlu(3'b000, 6'h18, 32'd2, 32'd3, 5'd0);
        #1;
        check("opMul", 32'(bus.ALUOp), 32'd6);
        tick();

        alu("div6_3",  3'b000, 6'h1A, 32'd6, 32'd3, 5'd0, 32'd0);
        alu("mfhi6_3", 3'b000, 6'h10, 32'd0, 32'd0, 5'd0, 32'd0);
        alu("mflo6_3", 3'b000, 6'h12, 32'd0, 32'd0, 5'd0, 32'd2);
        setAlu(3'b000, 6'h12, 32'd0, 32'd0, 5'd0);
        #1;
        check("opMflo", 32'(bus.ALUOp), 32'd9);
        tick();
        alu("div1_3",  3'b000, 6'h1A, 32'd1, 32'd3, 5'd0, 32'd0);
        alu("mfhi1_3", 3'b000, 6'h10, 32'd0, 32'd0, 5'd0, 32'd1);
        alu("div11_3", 3'b000, 6'h1A, 32'd11, 32'd3, 5'd0, 32'd0);
        alu("mfhi11",  3'b000, 6'h10, 32'd0, 32'd0, 5'd0, 32'd2);
        alu("mflo11",  3'b000, 6'h12, 32'd0, 32'd0, 5'd0, 32'd3);
        alu("divM7_2", 3'b000, 6'h1A, 32'hFFFF_FFF9, 32'd2, 5'd0, 32'd0);
        alu("mfhiM7",  3'b000, 6'h10, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF);
        alu("mfloM7",  3'b000, 6'h12, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFD);
        alu("div7_M2", 3'b000, 6'h1A, 32'd7, 32'hFFFF_FFFE, 5'd0, 32'd0);
        alu("div5_0",  3'b000, 6'h1A, 32'd5, 32'd0, 5'd0, 32'd0);
        alu("mfhiKeep",3'b000, 6'h10, 32'd0, 32'd0, 5'd0, 32'd1);
        alu("mfloKeep",3'b000, 6'h12, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFD);

        // Reset in mid-cycle clears HI/LO without a clock edge.
        setAlu(3'b000, 6'h10, 32'd0, 32'd0, 5'd0);
        rst = 1'b1;
        #1;
        check("asyncRstHi", bus.ALUOut, 32'd0);
        tick();
        rst = 1'b0;
        alu("div20_3", 3'b000, 6'h1A, 32'd20, 32'd3, 5'd0, 32'd0);
        alu("mfhi20",  3'b000, 6'h10, 32'd0, 32'd0, 5'd0, 32'd2);

        // DIV sampled while reset is high must not load.
        rst = 1'b1;
        setAlu(3'b000, 6'h1A, 32'd10, 32'd3, 5'd0);
        tick();
        rst = 1'b0;
        alu("rstDivHi", 3'b000, 6'h10, 32'd0, 32'd0, 5'd0, 32'd0);
        alu("rstDivLo", 3'b000, 6'h12, 32'd0, 32'd0, 5'd0, 32'd0);

        //   name       rs rt exRd wbRd exRw exMw wbRw m2r  A      B      C
        fwd("fwdEx",    5, 3, 5,   5,   1,   0,   1,   0,   2'b10, 2'b00, 1'b0);
        fwd("fwdWb",    5, 3, 5,   5,   0,   0,   1,   0,   2'b01, 2'b00, 1'b0);
        fwd("fwdZero",  0, 0, 0,   0,   1,   0,   1,   0,   2'b00, 2'b00, 1'b0);
        fwd("fwdStore", 5, 3, 5,   5,   1,   1,   1,   0,   2'b01, 2'b00, 1'b0);
        fwd("fwdB",     2, 7, 7,   2,   1,   0,   1,   0,   2'b01, 2'b10, 1'b0);
        fwd("fwdC",     1, 2, 9,   9,   0,   1,   1,   1,   2'b00, 2'b00, 1'b1);
        fwd("fwdC0",    1, 2, 0,   0,   0,   1,   1,   1,   2'b00, 2'b00, 1'b0);
        fwd("fwdCnoLd", 1, 2, 9,   9,   0,   1,   1,   0,   2'b00, 2'b00, 1'b0);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
